// File: rtl/batchnorm_stream_mc.sv
// Streaming per-channel batch-norm inference: y = gamma*((x-mean)*inv_std) + beta in signed
// Q(WIDTH-FRAC).FRAC, with a host-loaded parameter table and a 3-stage valid/ready pipeline.
module batchnorm_stream_mc #(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned FRAC     = 8,
  parameter  int unsigned CHANNELS = 4,
  localparam int unsigned CH_W     = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             bypass,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic [CH_W-1:0]  s_ch,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CH_W-1:0]  m_ch,
  output logic             m_sat,
  output logic [15:0]      sat_count
);
  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1) <<< (FRAC - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC;

  // Clamp to WIDTH bits; returns {saturated, value}.
  function automatic logic [WIDTH:0] sat_fn(input logic signed [PW-1:0] v);
    logic all_ones;
    logic all_zeros;
    all_ones  = &v[PW-1:WIDTH-1];
    all_zeros = ~|v[PW-1:WIDTH-1];
    if (all_ones | all_zeros) sat_fn = {1'b0, v[WIDTH-1:0]};
    else                      sat_fn = {1'b1, v[PW-1], {(WIDTH-1){~v[PW-1]}}};
  endfunction

  logic [WIDTH-1:0] gamma_tab [CHANNELS];
  logic [WIDTH-1:0] beta_tab  [CHANNELS];
  logic [WIDTH-1:0] mean_tab  [CHANNELS];
  logic [WIDTH-1:0] inv_tab   [CHANNELS];

  logic [WIDTH-1:0] rd_gamma, rd_beta, rd_mean, rd_inv;
  logic adv;

  logic                    s1_v, s1_byp;
  logic [CH_W-1:0]         s1_ch;
  logic [WIDTH-1:0]        s1_x;
  logic signed [DW-1:0]    s1_d;
  logic signed [WIDTH-1:0] s1_inv, s1_gamma, s1_beta;

  logic                    s2_v, s2_byp, s2_sat;
  logic [CH_W-1:0]         s2_ch;
  logic [WIDTH-1:0]        s2_x;
  logic signed [WIDTH-1:0] s2_n, s2_gamma, s2_beta;

  logic signed [DW-1:0]    d_c;
  logic signed [PW-1:0]    p_c, p_rnd, n_full;
  logic signed [PW-1:0]    q_c, q_rnd, r_full;
  logic [WIDTH:0]          n_res, r_res;

  assign adv     = m_ready | ~m_valid;
  assign s_ready = adv;

  // Parameter table; out-of-range cfg_ch matches no entry and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        gamma_tab[i] <= ONE;
        beta_tab[i]  <= '0;
        mean_tab[i]  <= '0;
        inv_tab[i]   <= ONE;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (cfg_ch == CH_W'(i)) begin
          case (cfg_sel)
            2'd0:    gamma_tab[i] <= cfg_data;
            2'd1:    beta_tab[i]  <= cfg_data;
            2'd2:    mean_tab[i]  <= cfg_data;
            default: inv_tab[i]   <= cfg_data;
          endcase
        end
      end
    end
  end

  // Parameter lookup; unknown channels fall back to entry 0.
  always_comb begin
    rd_gamma = gamma_tab[0];
    rd_beta  = beta_tab[0];
    rd_mean  = mean_tab[0];
    rd_inv   = inv_tab[0];
    for (int i = 1; i < int'(CHANNELS); i++) begin
      if (s_ch == CH_W'(i)) begin
        rd_gamma = gamma_tab[i];
        rd_beta  = beta_tab[i];
        rd_mean  = mean_tab[i];
        rd_inv   = inv_tab[i];
      end
    end
  end

  always_comb begin
    d_c    = DW'($signed(s_data)) - DW'($signed(rd_mean));
    p_c    = PW'(s1_d) * PW'(s1_inv);
    p_rnd  = p_c + HALF;
    n_full = p_rnd >>> FRAC;
    n_res  = sat_fn(n_full);
    q_c    = PW'(s2_n) * PW'(s2_gamma);
    q_rnd  = q_c + HALF;
    r_full = (q_rnd >>> FRAC) + PW'(s2_beta);
    r_res  = sat_fn(r_full);
  end

  // Whole pipe moves together on adv, bubbles included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v <= 1'b0; s1_byp <= 1'b0; s1_ch <= '0; s1_x <= '0; s1_d <= '0;
      s1_inv <= '0; s1_gamma <= '0; s1_beta <= '0;
      s2_v <= 1'b0; s2_byp <= 1'b0; s2_sat <= 1'b0; s2_ch <= '0; s2_x <= '0;
      s2_n <= '0; s2_gamma <= '0; s2_beta <= '0;
      m_valid <= 1'b0; m_data <= '0; m_ch <= '0; m_sat <= 1'b0;
    end else if (adv) begin
      s1_v     <= s_valid;
      s1_byp   <= bypass;
      s1_ch    <= s_ch;
      s1_x     <= s_data;
      s1_d     <= d_c;
      s1_inv   <= rd_inv;
      s1_gamma <= rd_gamma;
      s1_beta  <= rd_beta;
      s2_v     <= s1_v;
      s2_byp   <= s1_byp;
      s2_ch    <= s1_ch;
      s2_x     <= s1_x;
      s2_n     <= n_res[WIDTH-1:0];
      s2_sat   <= n_res[WIDTH];
      s2_gamma <= s1_gamma;
      s2_beta  <= s1_beta;
      m_valid  <= s2_v;
      m_ch     <= s2_ch;
      m_data   <= s2_byp ? s2_x : r_res[WIDTH-1:0];
      m_sat    <= ~s2_byp & (s2_sat | r_res[WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count <= '0;
    else if (m_valid && m_ready && m_sat && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_batchnorm_stream_mc.sv
// Bench for batchnorm_stream_mc: directed corner cases plus randomized streams checked
// against an integer reference model of the normalisation.
module tb_batchnorm_stream_mc;
  localparam int CHANNELS = 4;
  localparam int FRAC     = 8;
  localparam longint SCALE = 256;
  localparam longint HALFV = 128;
  localparam longint MAXV  = 32767;
  localparam longint MINV  = -32768;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  ch;
    logic        sat;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [1:0]  cfg_ch, cfg_sel;
  logic [15:0] cfg_data;
  logic        bypass, s_valid, s_ready;
  logic [15:0] s_data;
  logic [1:0]  s_ch;
  logic        m_valid, m_ready;
  logic [15:0] m_data;
  logic [1:0]  m_ch;
  logic        m_sat;
  logic [15:0] sat_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] t_gamma [CHANNELS];
  logic [15:0] t_beta  [CHANNELS];
  logic [15:0] t_mean  [CHANNELS];
  logic [15:0] t_inv   [CHANNELS];

  item_t exp_q[$];
  item_t got_q[$];
  item_t held;
  bit    stall_armed;
  int    stall_viol;
  bit    last_acc;

  always #5 clk = ~clk;

  batchnorm_stream_mc #(.WIDTH(16), .FRAC(FRAC), .CHANNELS(CHANNELS)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .bypass(bypass), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_ch(s_ch), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_ch(m_ch), .m_sat(m_sat), .sat_count(sat_count)
  );

  // Rounded fixed-point rescale: floor((v + 0.5 LSB) / 2^FRAC).
  function automatic longint rescale(input longint v);
    longint num, q;
    num = v + HALFV;
    q = num / SCALE;
    if ((num % SCALE) != 0 && num < 0) q = q - 1;
    return q;
  endfunction

  function automatic longint clamp(input longint v, output bit sat);
    sat = (v > MAXV) || (v < MINV);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  function automatic item_t model(input logic [15:0] x, input logic [1:0] ch, input logic byp);
    longint d, n, r;
    bit s2, s3;
    int c;
    item_t it;
    c = (int'(ch) < CHANNELS) ? int'(ch) : 0;
    it.ch = ch;
    if (byp) begin
      it.data = x;
      it.sat = 1'b0;
      return it;
    end
    d = longint'($signed(x)) - longint'($signed(t_mean[c]));
    n = clamp(rescale(d * longint'($signed(t_inv[c]))), s2);
    r = rescale(n * longint'($signed(t_gamma[c]))) + longint'($signed(t_beta[c]));
    r = clamp(r, s3);
    it.data = 16'(r);
    it.sat = s2 | s3;
    return it;
  endfunction

  function automatic logic [15:0] rand_param(input logic [1:0] sel);
    if ($urandom_range(0, 7) == 0) return 16'($urandom);
    if (sel == 2'd0 || sel == 2'd3) return 16'($urandom_range(0, 1023)) - 16'd256;
    return 16'($urandom_range(0, 2047)) - 16'd1024;
  endfunction

  function automatic logic [15:0] rand_x();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 4095)) - 16'd2048;
  endfunction

  // One clock: observe handshakes at the falling edge, update the model table, return after the rising edge.
  task automatic step();
    @(negedge clk);
    if (stall_armed && (m_valid !== 1'b1 || m_data !== held.data || m_ch !== held.ch || m_sat !== held.sat))
      stall_viol++;
    stall_armed = m_valid && !m_ready;
    held = '{m_data, m_ch, m_sat};
    last_acc = s_valid && s_ready;
    if (last_acc) exp_q.push_back(model(s_data, s_ch, bypass));
    if (m_valid && m_ready) got_q.push_back('{m_data, m_ch, m_sat});
    if (cfg_we && int'(cfg_ch) < CHANNELS) begin
      case (cfg_sel)
        2'd0: t_gamma[cfg_ch] = cfg_data;
        2'd1: t_beta[cfg_ch]  = cfg_data;
        2'd2: t_mean[cfg_ch]  = cfg_data;
        default: t_inv[cfg_ch] = cfg_data;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    bypass = 1'b0; s_valid = 1'b0; s_data = '0; s_ch = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      t_gamma[i] = 16'h0100; t_beta[i] = '0; t_mean[i] = '0; t_inv[i] = 16'h0100;
    end
    exp_q.delete(); got_q.delete();
    stall_armed = 1'b0; stall_viol = 0; last_acc = 1'b0;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel, input logic [15:0] data);
    cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send_one(input logic [15:0] x, input logic [1:0] ch, input logic byp);
    s_valid = 1'b1; s_data = x; s_ch = ch; bypass = byp; m_ready = 1'b1;
    step();
    s_valid = 1'b0; bypass = 1'b0;
  endtask

  task automatic drain();
    s_valid = 1'b0; cfg_we = 1'b0; m_ready = 1'b1;
    repeat (6) step();
  endtask

  task automatic run_stream(input int n, input bit do_cfg, input bit do_byp, output int sent);
    int cyc;
    logic [15:0] cx;
    logic [1:0] cc;
    logic cb;
    sent = 0; cyc = 0;
    cx = rand_x(); cc = 2'd0; cb = do_byp ? 1'($urandom_range(0, 1)) : 1'b0;
    while (sent < n && cyc < n * 20) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data = cx; s_ch = cc; bypass = cb;
      m_ready = ($urandom_range(0, 2) != 0);
      cfg_we = do_cfg && ($urandom_range(0, 5) == 0);
      cfg_ch = 2'($urandom_range(0, 3));
      cfg_sel = 2'($urandom_range(0, 3));
      cfg_data = rand_param(cfg_sel);
      step();
      cyc++;
      if (last_acc) begin
        sent++;
        cx = rand_x();
        cc = do_cfg ? 2'($urandom_range(0, 3)) : 2'(sent % 4);
        cb = do_byp ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    bypass = 1'b0;
    drain();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_ready = 1'b0; s_valid = 1'b0; cfg_we = 1'b0;
    #3;
    checks++;
    if (m_valid !== 1'b0 || m_data !== 16'h0 || m_ch !== 2'd0 || m_sat !== 1'b0 || sat_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h ch=%0d sat=%b cnt=%0d want all zero", m_valid, m_data, m_ch, m_sat, sat_count);
    end
    apply_reset();
    m_ready = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_s_ready got %b want 1", s_ready);
    end
    m_ready = 1'b1;
  endtask

  task automatic test_identity();
    apply_reset();
    send_one(16'h0300, 2'd0, 1'b0);
    step();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL identity_early got m_valid=%b want 0", m_valid);
    end
    step();
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h0300 || m_sat !== 1'b0 || m_ch !== 2'd0) begin
      errors++;
      $display("FAIL identity_latency got v=%b d=%h sat=%b ch=%0d want v=1 d=0300 sat=0 ch=0", m_valid, m_data, m_sat, m_ch);
    end
    drain();
  endtask

  task automatic test_fixed_params();
    apply_reset();
    cfg_write(2'd2, 2'd2, 16'h0100);
    cfg_write(2'd2, 2'd3, 16'h0080);
    cfg_write(2'd2, 2'd0, 16'h0200);
    cfg_write(2'd2, 2'd1, 16'h0080);
    send_one(16'h0300, 2'd2, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== item_t'{16'h0280, 2'd2, 1'b0}) begin
      errors++;
      $display("FAIL fixed_params got n=%0d first=%h want one item d=0280 ch=2 sat=0", got_q.size(), (got_q.size() > 0) ? got_q[0] : item_t'('0));
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    cfg_write(2'd1, 2'd2, 16'h8000);
    send_one(16'h7F00, 2'd1, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0].data !== 16'h7FFF || got_q[0].sat !== 1'b1 || sat_count !== 16'd1) begin
      errors++;
      $display("FAIL sat_pos got n=%0d d=%h sat=%b cnt=%0d want d=7FFF sat=1 cnt=1", got_q.size(),
               (got_q.size() > 0) ? got_q[0].data : 16'h0, (got_q.size() > 0) ? got_q[0].sat : 1'b0, sat_count);
    end
    cfg_write(2'd1, 2'd0, 16'h7FFF);
    cfg_write(2'd1, 2'd2, 16'h7F00);
    send_one(16'h8000, 2'd1, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[1].data !== 16'h8000 || got_q[1].sat !== 1'b1 || sat_count !== 16'd2) begin
      errors++;
      $display("FAIL sat_neg got n=%0d d=%h sat=%b cnt=%0d want d=8000 sat=1 cnt=2", got_q.size(),
               (got_q.size() > 1) ? got_q[1].data : 16'h0, (got_q.size() > 1) ? got_q[1].sat : 1'b0, sat_count);
    end
    send_one(16'h1234, 2'd1, 1'b1);
    drain();
    checks++;
    if (got_q.size() != 3 || got_q[2] !== item_t'{16'h1234, 2'd1, 1'b0} || sat_count !== 16'd2) begin
      errors++;
      $display("FAIL bypass_passthru got n=%0d cnt=%0d want d=1234 ch=1 sat=0 cnt=2", got_q.size(), sat_count);
    end
  endtask

  task automatic test_config_race();
    apply_reset();
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_sel = 2'd2; cfg_data = 16'h0100;
    s_valid = 1'b1; s_data = 16'h0200; s_ch = 2'd0; m_ready = 1'b1;
    step();
    cfg_we = 1'b0;
    step();
    drain();
    checks++;
    if (got_q.size() != 2 || got_q[0].data !== 16'h0200 || got_q[1].data !== 16'h0100) begin
      errors++;
      $display("FAIL config_race got n=%0d d0=%h d1=%h want 0200 then 0100", got_q.size(),
               (got_q.size() > 0) ? got_q[0].data : 16'h0, (got_q.size() > 1) ? got_q[1].data : 16'h0);
    end
  endtask

  task automatic test_back_to_back();
    int sent, sat_exp;
    apply_reset();
    for (int c = 0; c < CHANNELS; c++)
      for (int s = 0; s < 4; s++) cfg_write(2'(c), 2'(s), rand_param(2'(s)));
    run_stream(8, 1'b0, 1'b0, sent);
    checks++;
    if (sent != 8 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count sent=%0d got=%0d want=%0d", sent, got_q.size(), exp_q.size());
    end
    sat_exp = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_item %0d got d=%h ch=%0d sat=%b want d=%h ch=%0d sat=%b", i,
                 got_q[i].data, got_q[i].ch, got_q[i].sat, exp_q[i].data, exp_q[i].ch, exp_q[i].sat);
      end
      if (exp_q[i].sat) sat_exp++;
    end
    checks++;
    if (stall_viol != 0 || sat_count !== 16'(sat_exp)) begin
      errors++;
      $display("FAIL b2b_stall_satcnt stall_viol=%0d cnt=%0d want 0 and %0d", stall_viol, sat_count, sat_exp);
    end
  endtask

  task automatic test_random();
    int sent, sat_exp;
    apply_reset();
    for (int c = 0; c < CHANNELS; c++)
      for (int s = 0; s < 4; s++) cfg_write(2'(c), 2'(s), rand_param(2'(s)));
    run_stream(300, 1'b1, 1'b1, sent);
    checks++;
    if (sent != 300 || got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count sent=%0d got=%0d want=%0d", sent, got_q.size(), exp_q.size());
    end
    sat_exp = 0;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_item %0d got d=%h ch=%0d sat=%b want d=%h ch=%0d sat=%b", i,
                 got_q[i].data, got_q[i].ch, got_q[i].sat, exp_q[i].data, exp_q[i].ch, exp_q[i].sat);
      end
      if (exp_q[i].sat) sat_exp++;
    end
    checks++;
    if (stall_viol != 0 || sat_count !== 16'(sat_exp)) begin
      errors++;
      $display("FAIL rand_stall_satcnt stall_viol=%0d cnt=%0d want 0 and %0d", stall_viol, sat_count, sat_exp);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    cfg_write(2'd0, 2'd2, 16'h0050);
    m_ready = 1'b0; s_valid = 1'b1; s_ch = 2'd0; bypass = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = 16'h0100 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_fill got m_valid=%b want 1", m_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async got m_valid=%b want 0", m_valid);
    end
    apply_reset();
    repeat (6) step();
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_stale got %0d outputs want 0", got_q.size());
    end
    send_one(16'h0300, 2'd0, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 1 || got_q[0] !== item_t'{16'h0300, 2'd0, 1'b0}) begin
      errors++;
      $display("FAIL midreset_table got n=%0d d=%h want one item d=0300", got_q.size(),
               (got_q.size() > 0) ? got_q[0].data : 16'h0);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_fixed_params();
    test_saturation();
    test_config_race();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
